tdm_demux1_4: RTL and testbench
===============================

Name: tdm_demux1_4

Overview:
- Receive-side counterpart of the 4:1 channel mux: takes a time-division-multiplexed word stream (one channel per slot, 4 slots per frame) and distributes each word back to its own channel output register.
- Locks onto a frame marker, tracks the slot with an internal counter, and reports loss of frame alignment.
- Sits at the far end of a link driven by a mux whose select cycles 0,1,2,3.

Parameters:
- WIDTH, 4, bits per channel word (matches the mux data width per channel).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  TDM word for the current slot.
- valid_in  input  1  data_in carries a slot word this cycle.
- frame_in  input  1  qualified by valid_in; marks the slot-0 word of a frame.
- y0_out  output  WIDTH  channel 0 holding register.
- y1_out  output  WIDTH  channel 1 holding register.
- y2_out  output  WIDTH  channel 2 holding register.
- y3_out  output  WIDTH  channel 3 holding register.
- ch_valid_out  output  4  one-hot, 1-cycle pulse: channel n register updated this cycle.
- sel_out  output  2  slot index expected for the next valid word.
- locked_out  output  1  1 while in LOCK state.
- frame_done_out  output  1  1-cycle pulse when the slot-3 word of an aligned frame is captured.
- sync_err_out  output  1  1-cycle pulse on a frame alignment error.

Behaviour:
- Reset (sync, active-high; wins over all other inputs in that cycle):
  - y0..y3_out = 0, ch_valid_out = 0, sel_out = 0.
  - locked_out = 0, frame_done_out = 0, sync_err_out = 0, state = HUNT.
- All outputs are registered. A word accepted at edge N appears on yN_out/ch_valid_out after edge N, i.e. 1-cycle latency.
- Pulse outputs default to 0 in every cycle in which their condition does not fire.
- valid_in = 0: no state, counter or register change; all pulse outputs are 0.
- HUNT state:
  - valid_in & ~frame_in: word discarded, no error.
  - valid_in & frame_in: data_in -> y0_out, ch_valid_out = 0001, sel_out = 1, go to LOCK.
- LOCK state, valid_in = 1, s = sel_out:
  - s != 0, frame_in = 0:
    - data_in -> ys_out, ch_valid_out = one-hot(s), sel_out = s+1 (mod 4, 3 wraps to 0).
    - If s == 3, frame_done_out = 1.
  - s != 0, frame_in = 1 (early marker):
    - sync_err_out = 1; resynchronise on this word.
    - data_in -> y0_out, ch_valid_out = 0001, sel_out = 1, stay in LOCK.
    - Registers of the partial frame keep their values.
  - s == 0, frame_in = 1: normal slot-0 capture, y0_out updated, sel_out = 1.
  - s == 0, frame_in = 0 (missing marker):
    - sync_err_out = 1, word discarded, no register update.
    - sel_out = 0, locked_out = 0, go to HUNT.
- locked_out = 1 exactly while state = LOCK.
- frame_done_out and sync_err_out never assert in the same cycle.
- Gaps (valid_in low) inside a frame are legal and do not break lock.
- Reset mid-frame: everything returns to the reset values and the partial frame is lost. The first post-reset word is accepted only with frame_in = 1.
- Implementation: 1-bit state register, 2-bit slot counter, 4 x WIDTH holding registers, pulse registers.

Test Plan:
- Reset then idle: hold reset 2 cycles with valid_in = 1, frame_in = 1, data_in = A.
  -> All outputs 0 during reset; first capture of A occurs only on the edge after reset drops.
- Aligned frame with WIDTH = 4: words 3,5,A,C on consecutive cycles, frame_in on word 3.
  -> y0..y3 = 3,5,A,C, each one cycle after its input.
  -> ch_valid_out = 0001,0010,0100,1000.
  -> frame_done_out high the cycle y3 = C; locked_out = 1; sel_out wraps to 0.
- HUNT discard: words 7,8 without frame_in, then 9 with frame_in.
  -> 7 and 8 ignored with no sync_err; y0 = 9, locked_out rises, sel_out = 1.
- Early marker: after slot-0/1 words 1,2, a word 4 arrives with frame_in.
  -> sync_err_out pulse; y0 = 4, y1 stays 2, sel_out = 1, still locked.
- Missing marker: after a full frame, the next word arrives without frame_in.
  -> sync_err_out pulse, y0 unchanged, locked_out = 0, sel_out = 0.
- Gaps and mid-frame reset: frame 3,5,A,C with 2 idle cycles between words -> same result as the aligned case. Then assert reset after slot 2 of the next frame -> all outputs clear, state HUNT.

Source files
------------

// File: rtl/tdm_demux1_4.sv
// Receive-side TDM demultiplexer: locks onto a frame marker and steers each
// slot word of a 4-slot frame into its own channel holding register.
module tdm_demux1_4 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   input  logic             frame_in,
   output logic [WIDTH-1:0] y0_out,
   output logic [WIDTH-1:0] y1_out,
   output logic [WIDTH-1:0] y2_out,
   output logic [WIDTH-1:0] y3_out,
   output logic [3:0]       ch_valid_out,
   output logic [1:0]       sel_out,
   output logic             locked_out,
   output logic             frame_done_out,
   output logic             sync_err_out
);

   typedef enum logic {HUNT, LOCK} state_t;

   state_t                  state, state_nx;
   logic [1:0]              sel, sel_nx;
   logic [3:0][WIDTH-1:0]   y_q, y_nx;
   logic [3:0]              ch_q, ch_nx;
   logic                    done_q, done_nx;
   logic                    err_q, err_nx;

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= HUNT;
         sel    <= '0;
         y_q    <= '0;
         ch_q   <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         sel    <= sel_nx;
         y_q    <= y_nx;
         ch_q   <= ch_nx;
         done_q <= done_nx;
         err_q  <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      sel_nx   = sel;
      y_nx     = y_q;
      ch_nx    = '0;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      if (valid_in) begin
         unique case (state)
            HUNT: begin
               if (frame_in) begin
                  y_nx[0]  = data_in;
                  ch_nx    = 4'b0001;
                  sel_nx   = 2'd1;
                  state_nx = LOCK;
               end
            end
            LOCK: begin
               if (frame_in) begin
                  // A marker always restarts the frame at slot 0; off slot 0 it is also an error.
                  err_nx  = (sel != 2'd0);
                  y_nx[0] = data_in;
                  ch_nx   = 4'b0001;
                  sel_nx  = 2'd1;
               end else if (sel == 2'd0) begin
                  err_nx   = 1'b1;
                  sel_nx   = 2'd0;
                  state_nx = HUNT;
               end else begin
                  y_nx[sel] = data_in;
                  ch_nx     = 4'b0001 << sel;
                  sel_nx    = sel + 2'd1;
                  done_nx   = (sel == 2'd3);
               end
            end
            default: state_nx = HUNT;
         endcase
      end
   end

   assign y0_out         = y_q[0];
   assign y1_out         = y_q[1];
   assign y2_out         = y_q[2];
   assign y3_out         = y_q[3];
   assign ch_valid_out   = ch_q;
   assign sel_out        = sel;
   assign locked_out     = (state == LOCK);
   assign frame_done_out = done_q;
   assign sync_err_out   = err_q;

endmodule

// File: tb/tb_tdm_demux1_4.sv
// Directed bench for tdm_demux1_4: each step queues its expected outputs,
// which are popped and checked one clock later.
module tb_tdm_demux1_4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] data_in = '0;
   logic       valid_in = 1'b0;
   logic       frame_in = 1'b0;
   logic [3:0] y0_out, y1_out, y2_out, y3_out;
   logic [3:0] ch_valid_out;
   logic [1:0] sel_out;
   logic       locked_out, frame_done_out, sync_err_out;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   typedef struct {
      logic [3:0] y0, y1, y2, y3;
      logic [3:0] ch;
      logic [1:0] sel;
      logic       lk, dn, er;
   } exp_t;

   exp_t sb[$];

   tdm_demux1_4 #(.WIDTH(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .data_in       (data_in),
      .valid_in      (valid_in),
      .frame_in      (frame_in),
      .y0_out        (y0_out),
      .y1_out        (y1_out),
      .y2_out        (y2_out),
      .y3_out        (y3_out),
      .ch_valid_out  (ch_valid_out),
      .sel_out       (sel_out),
      .locked_out    (locked_out),
      .frame_done_out(frame_done_out),
      .sync_err_out  (sync_err_out)
   );

   always #5 clock = ~clock;

   function automatic exp_t mk(input logic [3:0] y0, y1, y2, y3, ch,
                               input logic [1:0] sel, input logic lk, dn, er);
      exp_t e;
      e.y0 = y0; e.y1 = y1; e.y2 = y2; e.y3 = y3;
      e.ch = ch; e.sel = sel; e.lk = lk; e.dn = dn; e.er = er;
      return e;
   endfunction

   task automatic cmp(input string tag, input int unsigned idx,
                      input logic [3:0] obs, input logic [3:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL step%0d %s observed=%h expected=%h", idx, tag, obs, exp_v);
      end
   endtask

   int unsigned step_no = 0;

   task automatic step(input logic r, v, f, input logic [3:0] d, input exp_t e);
      exp_t x;
      @(negedge clock);
      reset = r; valid_in = v; frame_in = f; data_in = d;
      sb.push_back(e);
      @(posedge clock);
      #1;
      step_no++;
      x = sb.pop_front();
      cmp("y0",    step_no, y0_out, x.y0);
      cmp("y1",    step_no, y1_out, x.y1);
      cmp("y2",    step_no, y2_out, x.y2);
      cmp("y3",    step_no, y3_out, x.y3);
      cmp("ch",    step_no, ch_valid_out, x.ch);
      cmp("sel",   step_no, {2'b00, sel_out}, {2'b00, x.sel});
      cmp("lock",  step_no, {3'b000, locked_out}, {3'b000, x.lk});
      cmp("done",  step_no, {3'b000, frame_done_out}, {3'b000, x.dn});
      cmp("err",   step_no, {3'b000, sync_err_out}, {3'b000, x.er});
   endtask

   initial begin
      // reset held with an active marker word: nothing captured
      step(1, 1, 1, 4'hA, mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      step(1, 1, 1, 4'hA, mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      step(0, 1, 1, 4'hA, mk(4'hA, 0, 0, 0, 4'h1, 1, 1, 0, 0));
      step(0, 1, 0, 4'h1, mk(4'hA, 4'h1, 0, 0, 4'h2, 2, 1, 0, 0));
      step(0, 1, 0, 4'h2, mk(4'hA, 4'h1, 4'h2, 0, 4'h4, 3, 1, 0, 0));
      step(0, 1, 0, 4'h6, mk(4'hA, 4'h1, 4'h2, 4'h6, 4'h8, 0, 1, 1, 0));
      // aligned frame 3,5,A,C
      step(0, 1, 1, 4'h3, mk(4'h3, 4'h1, 4'h2, 4'h6, 4'h1, 1, 1, 0, 0));
      step(0, 1, 0, 4'h5, mk(4'h3, 4'h5, 4'h2, 4'h6, 4'h2, 2, 1, 0, 0));
      step(0, 1, 0, 4'hA, mk(4'h3, 4'h5, 4'hA, 4'h6, 4'h4, 3, 1, 0, 0));
      step(0, 1, 0, 4'hC, mk(4'h3, 4'h5, 4'hA, 4'hC, 4'h8, 0, 1, 1, 0));
      step(0, 0, 1, 4'hF, mk(4'h3, 4'h5, 4'hA, 4'hC, 4'h0, 0, 1, 0, 0));
      // missing marker drops lock
      step(0, 1, 0, 4'h7, mk(4'h3, 4'h5, 4'hA, 4'hC, 4'h0, 0, 0, 0, 1));
      // hunt discards unmarked words silently
      step(0, 1, 0, 4'h7, mk(4'h3, 4'h5, 4'hA, 4'hC, 4'h0, 0, 0, 0, 0));
      step(0, 1, 0, 4'h8, mk(4'h3, 4'h5, 4'hA, 4'hC, 4'h0, 0, 0, 0, 0));
      step(0, 1, 1, 4'h9, mk(4'h9, 4'h5, 4'hA, 4'hC, 4'h1, 1, 1, 0, 0));
      step(0, 1, 0, 4'hB, mk(4'h9, 4'hB, 4'hA, 4'hC, 4'h2, 2, 1, 0, 0));
      step(0, 1, 0, 4'hD, mk(4'h9, 4'hB, 4'hD, 4'hC, 4'h4, 3, 1, 0, 0));
      step(0, 1, 0, 4'hE, mk(4'h9, 4'hB, 4'hD, 4'hE, 4'h8, 0, 1, 1, 0));
      // early marker resynchronises, partial frame registers kept
      step(0, 1, 1, 4'h1, mk(4'h1, 4'hB, 4'hD, 4'hE, 4'h1, 1, 1, 0, 0));
      step(0, 1, 0, 4'h2, mk(4'h1, 4'h2, 4'hD, 4'hE, 4'h2, 2, 1, 0, 0));
      step(0, 1, 1, 4'h4, mk(4'h4, 4'h2, 4'hD, 4'hE, 4'h1, 1, 1, 0, 1));
      step(0, 1, 0, 4'hF, mk(4'h4, 4'hF, 4'hD, 4'hE, 4'h2, 2, 1, 0, 0));
      step(0, 1, 0, 4'h6, mk(4'h4, 4'hF, 4'h6, 4'hE, 4'h4, 3, 1, 0, 0));
      step(0, 1, 0, 4'h7, mk(4'h4, 4'hF, 4'h6, 4'h7, 4'h8, 0, 1, 1, 0));
      // gapped frame 3,5,A,C with two idle cycles between words
      step(0, 1, 1, 4'h3, mk(4'h3, 4'hF, 4'h6, 4'h7, 4'h1, 1, 1, 0, 0));
      step(0, 0, 0, 4'h0, mk(4'h3, 4'hF, 4'h6, 4'h7, 4'h0, 1, 1, 0, 0));
      step(0, 0, 1, 4'h9, mk(4'h3, 4'hF, 4'h6, 4'h7, 4'h0, 1, 1, 0, 0));
      step(0, 1, 0, 4'h5, mk(4'h3, 4'h5, 4'h6, 4'h7, 4'h2, 2, 1, 0, 0));
      step(0, 0, 0, 4'h0, mk(4'h3, 4'h5, 4'h6, 4'h7, 4'h0, 2, 1, 0, 0));
      step(0, 0, 0, 4'h0, mk(4'h3, 4'h5, 4'h6, 4'h7, 4'h0, 2, 1, 0, 0));
      step(0, 1, 0, 4'hA, mk(4'h3, 4'h5, 4'hA, 4'h7, 4'h4, 3, 1, 0, 0));
      step(0, 0, 0, 4'h0, mk(4'h3, 4'h5, 4'hA, 4'h7, 4'h0, 3, 1, 0, 0));
      step(0, 0, 0, 4'h0, mk(4'h3, 4'h5, 4'hA, 4'h7, 4'h0, 3, 1, 0, 0));
      step(0, 1, 0, 4'hC, mk(4'h3, 4'h5, 4'hA, 4'hC, 4'h8, 0, 1, 1, 0));
      step(0, 0, 0, 4'h0, mk(4'h3, 4'h5, 4'hA, 4'hC, 4'h0, 0, 1, 0, 0));
      // partial frame then mid-frame reset
      step(0, 1, 1, 4'h1, mk(4'h1, 4'h5, 4'hA, 4'hC, 4'h1, 1, 1, 0, 0));
      step(0, 1, 0, 4'h2, mk(4'h1, 4'h2, 4'hA, 4'hC, 4'h2, 2, 1, 0, 0));
      step(0, 1, 0, 4'h3, mk(4'h1, 4'h2, 4'h3, 4'hC, 4'h4, 3, 1, 0, 0));
      step(1, 1, 0, 4'h4, mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      step(0, 1, 0, 4'h5, mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
      step(0, 1, 1, 4'h6, mk(4'h6, 0, 0, 0, 4'h1, 1, 1, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
